// File: rtl/iobuf_pkg.sv
// Shared encodings for the I/O buffer bank: per-channel mode field and channel FSM states.
package iobuf_pkg;

  typedef enum logic [1:0] {
    MODE_IN  = 2'b00,
    MODE_PP  = 2'b01,
    MODE_OD  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IN    = 2'b00,
    ST_DRAIN = 2'b01,
    ST_TURN  = 2'b10,
    ST_OUT   = 2'b11
  } chan_state_e;

endpackage

// File: rtl/iobuf_chan.sv
// One bidirectional channel: break-before-make direction FSM, settle counter,
// output data register, 2-FF input synchroniser and optional stable-level filter.
module iobuf_chan
  import iobuf_pkg::*;
#(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned FILT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       dout,
  input  logic       pin_din,
  output logic       din,
  output logic       busy,
  output logic       pin_oe,
  output logic       pin_dout,
  output logic       buf_dir,
  output logic       buf_od
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tgt_out_q, tgt_out_d;
  logic          tgt_od_q, tgt_od_d;
  logic          pin_oe_q, pin_oe_d;
  logic          buf_dir_q, buf_dir_d;
  logic          buf_od_q, buf_od_d;
  logic          busy_q, busy_d;
  logic          pin_dout_q;
  logic          sync1_q, sync2_q;
  logic          t_out, t_od, cnt_last;

  assign t_out    = (mode == MODE_PP) || (mode == MODE_OD);
  assign t_od     = (mode == MODE_OD);
  assign cnt_last = (cnt_q == CW'(SETTLE - 1));

  // Next-state: target latched on leaving IN/OUT; buffer controls only move at DRAIN end or IN exit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_out_d = tgt_out_q;
    tgt_od_d  = tgt_od_q;
    buf_dir_d = buf_dir_q;
    buf_od_d  = buf_od_q;
    unique case (state_q)
      ST_IN: begin
        if (t_out) begin
          tgt_out_d = 1'b1;
          tgt_od_d  = t_od;
          buf_dir_d = 1'b1;
          buf_od_d  = t_od;
          cnt_d     = '0;
          state_d   = ST_TURN;
        end
      end
      ST_OUT: begin
        if (!t_out || (t_od != buf_od_q)) begin
          tgt_out_d = t_out;
          tgt_od_d  = t_od;
          cnt_d     = '0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_last) begin
          buf_dir_d = tgt_out_q;
          buf_od_d  = tgt_od_q;
          cnt_d     = '0;
          state_d   = ST_TURN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TURN: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = tgt_out_q ? ST_OUT : ST_IN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IN;
    endcase
    pin_oe_d = (state_d == ST_OUT);
    busy_d   = (state_d == ST_DRAIN) || (state_d == ST_TURN);
  end

  // Channel state and registered pad/buffer controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IN;
      cnt_q      <= '0;
      tgt_out_q  <= 1'b0;
      tgt_od_q   <= 1'b0;
      pin_oe_q   <= 1'b0;
      buf_dir_q  <= 1'b0;
      buf_od_q   <= 1'b0;
      busy_q     <= 1'b0;
      pin_dout_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_out_q  <= tgt_out_d;
      tgt_od_q   <= tgt_od_d;
      pin_oe_q   <= pin_oe_d;
      buf_dir_q  <= buf_dir_d;
      buf_od_q   <= buf_od_d;
      busy_q     <= busy_d;
      pin_dout_q <= dout;
      sync1_q    <= pin_din;
      sync2_q    <= sync1_q;
    end
  end

  generate
    if (FILT == 0) begin : g_bypass
      assign din = sync2_q;
    end else begin : g_filt
      localparam int unsigned FW = $clog2(FILT + 1);
      logic [FW-1:0] fcnt_q, fcnt_d;
      logic          din_q, din_d;

      // Accept a new level only after it has disagreed with din for FILT cycles in a row
      always_comb begin
        fcnt_d = '0;
        din_d  = din_q;
        if (sync2_q != din_q) begin
          if (fcnt_q == FW'(FILT - 1)) begin
            din_d = sync2_q;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end

      // Filter state
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fcnt_q <= '0;
          din_q  <= 1'b0;
        end else begin
          fcnt_q <= fcnt_d;
          din_q  <= din_d;
        end
      end

      assign din = din_q;
    end
  endgenerate

  assign pin_oe   = pin_oe_q;
  assign pin_dout = pin_dout_q;
  assign buf_dir  = buf_dir_q;
  assign buf_od   = buf_od_q;
  assign busy     = busy_q;

endmodule

// File: rtl/iobuf_bank.sv
// Bank of independent bidirectional channels; slices the packed port buses per channel.
module iobuf_bank
  import iobuf_pkg::*;
#(
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned FILT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   dout,
  output logic [CHANNELS-1:0]   din,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   pin_oe,
  output logic [CHANNELS-1:0]   pin_dout,
  input  logic [CHANNELS-1:0]   pin_din,
  output logic [CHANNELS-1:0]   buf_dir,
  output logic [CHANNELS-1:0]   buf_od
);

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_chan
      iobuf_chan #(
        .SETTLE (SETTLE),
        .FILT   (FILT)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode[2*i +: 2]),
        .dout     (dout[i]),
        .pin_din  (pin_din[i]),
        .din      (din[i]),
        .busy     (busy[i]),
        .pin_oe   (pin_oe[i]),
        .pin_dout (pin_dout[i]),
        .buf_dir  (buf_dir[i]),
        .buf_od   (buf_od[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_iobuf_bank.sv
// Scenario bench for iobuf_bank: expected per-cycle values are queued when stimulus
// is applied and popped as each clock edge is observed.
module tb_iobuf_bank;

  localparam int unsigned CH = 5;
  localparam int unsigned S  = 4;
  localparam int unsigned F  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   dout, din, busy, pin_oe, pin_dout, pin_din, buf_dir, buf_od;

  logic [1:0] nf_mode;
  logic       nf_dout, nf_din, nf_busy, nf_pin_oe, nf_pin_dout, nf_pin_din, nf_buf_dir, nf_buf_od;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0]    ctl_q[$];   // {pin_oe, buf_dir, buf_od, busy}
  logic [1:0]    din_q[$];   // {filtered din[3], unfiltered nf_din}
  logic [CH-1:0] dout_q[$];

  iobuf_bank #(.CHANNELS(CH), .SETTLE(S), .FILT(F)) dut (
    .clk(clk), .rst(rst), .mode(mode), .dout(dout), .din(din), .busy(busy),
    .pin_oe(pin_oe), .pin_dout(pin_dout), .pin_din(pin_din),
    .buf_dir(buf_dir), .buf_od(buf_od)
  );

  iobuf_bank #(.CHANNELS(1), .SETTLE(S), .FILT(0)) dut_nf (
    .clk(clk), .rst(rst), .mode(nf_mode), .dout(nf_dout), .din(nf_din), .busy(nf_busy),
    .pin_oe(nf_pin_oe), .pin_dout(nf_pin_dout), .pin_din(nf_pin_din),
    .buf_dir(nf_buf_dir), .buf_od(nf_buf_od)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ctl(input int unsigned ch);
    return {pin_oe[ch], buf_dir[ch], buf_od[ch], busy[ch]};
  endfunction

  task automatic push_ctl(input logic [3:0] v, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) ctl_q.push_back(v);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = '0; dout = '0; pin_din = '0;
    nf_mode = '0; nf_dout = 1'b0; nf_pin_din = 1'b0;
    tick(); tick();
    checks++;
    if ({pin_oe, buf_dir, buf_od, busy, din, pin_dout} !== '0) begin
      errors++;
      $display("FAIL reset_init: got oe=%b dir=%b od=%b busy=%b din=%b pdout=%b, want all 0",
               pin_oe, buf_dir, buf_od, busy, din, pin_dout);
    end
    rst = 1'b0;
    mode[1:0] = 2'b01;
    for (int unsigned k = 0; k < S + 1; k++) tick();
    checks++;
    if (ctl(0) !== 4'b1100) begin
      errors++;
      $display("FAIL reset_pre_out: ch0 ctl=%b want 1100", ctl(0));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({pin_oe[0], buf_dir[0]} !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: pin_oe=%b buf_dir=%b want 0 0", pin_oe[0], buf_dir[0]);
    end
    mode = '0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({pin_oe, buf_dir, buf_od, busy, din, pin_dout} !== '0) begin
      errors++;
      $display("FAIL reset_release: got oe=%b dir=%b od=%b busy=%b din=%b pdout=%b, want all 0",
               pin_oe, buf_dir, buf_od, busy, din, pin_dout);
    end
  endtask

  task automatic test_in_to_out();
    logic [3:0] e;
    push_ctl(4'b0101, S);
    push_ctl(4'b1100, 2);
    mode[3:2] = 2'b01;
    for (int unsigned j = 0; j < S + 2; j++) begin
      tick();
      e = ctl_q.pop_front();
      checks++;
      if (ctl(1) !== e || (pin_oe & ~buf_dir) !== '0) begin
        errors++;
        $display("FAIL in_to_out k+%0d: ctl=%b want %b (oe=%b dir=%b)", j, ctl(1), e, pin_oe, buf_dir);
      end
    end
  endtask

  task automatic test_out_to_in();
    logic [3:0] e;
    push_ctl(4'b0101, S);
    push_ctl(4'b0001, S);
    push_ctl(4'b0000, 2);
    mode[3:2] = 2'b00;
    for (int unsigned j = 0; j < 2*S + 2; j++) begin
      tick();
      e = ctl_q.pop_front();
      checks++;
      if (ctl(1) !== e || (pin_oe & ~buf_dir) !== '0) begin
        errors++;
        $display("FAIL out_to_in k+%0d: ctl=%b want %b (oe=%b dir=%b)", j, ctl(1), e, pin_oe, buf_dir);
      end
    end
  endtask

  task automatic test_pp_to_od();
    logic [3:0] e;
    mode[3:2] = 2'b01;
    for (int unsigned k = 0; k < S + 2; k++) tick();
    push_ctl(4'b0101, S);
    push_ctl(4'b0111, S);
    push_ctl(4'b1110, 2);
    mode[3:2] = 2'b10;
    for (int unsigned j = 0; j < 2*S + 2; j++) begin
      tick();
      e = ctl_q.pop_front();
      checks++;
      if (ctl(1) !== e || (pin_oe & ~buf_dir) !== '0) begin
        errors++;
        $display("FAIL pp_to_od k+%0d: ctl=%b want %b (oe=%b dir=%b)", j, ctl(1), e, pin_oe, buf_dir);
      end
    end
    mode[3:2] = 2'b00;
    for (int unsigned k = 0; k < 2*S + 1; k++) tick();
    checks++;
    if (ctl(1) !== 4'b0000) begin
      errors++;
      $display("FAIL od_to_in_final: ctl=%b want 0000", ctl(1));
    end
  endtask

  task automatic test_toggle_in_turn();
    logic [3:0] e;
    push_ctl(4'b0101, S);
    push_ctl(4'b1100, 1);
    push_ctl(4'b0101, S);
    push_ctl(4'b0001, S);
    push_ctl(4'b0000, 2);
    mode[5:4] = 2'b01;
    for (int unsigned j = 0; j < 3*S + 3; j++) begin
      tick();
      e = ctl_q.pop_front();
      checks++;
      if (ctl(2) !== e || (pin_oe & ~buf_dir) !== '0) begin
        errors++;
        $display("FAIL toggle_in_turn k+%0d: ctl=%b want %b (oe=%b dir=%b)", j, ctl(2), e, pin_oe, buf_dir);
      end
      if (j == 0) mode[5:4] = 2'b00;
    end
  endtask

  task automatic test_filter();
    logic [1:0] e;
    // 2-cycle pulse: filtered channel ignores it, unfiltered follows 2 cycles later
    for (int unsigned j = 0; j < 8; j++) din_q.push_back({1'b0, (j == 1 || j == 2)});
    pin_din[3] = 1'b1; nf_pin_din = 1'b1;
    for (int unsigned j = 0; j < 8; j++) begin
      tick();
      e = din_q.pop_front();
      checks++;
      if ({din[3], nf_din} !== e) begin
        errors++;
        $display("FAIL filter_pulse k+%0d: din={%b,%b} want %b", j, din[3], nf_din, e);
      end
      if (j == 1) begin
        pin_din[3] = 1'b0; nf_pin_din = 1'b0;
      end
    end
    // Stable rise then stable fall
    for (int unsigned lvl = 1; lvl <= 2; lvl++) begin
      logic v;
      v = (lvl == 1);
      for (int unsigned j = 0; j < 7; j++)
        din_q.push_back({(j >= 2 + F - 1) ? v : ~v, (j >= 1) ? v : ~v});
      pin_din[3] = v; nf_pin_din = v;
      for (int unsigned j = 0; j < 7; j++) begin
        tick();
        e = din_q.pop_front();
        checks++;
        if ({din[3], nf_din} !== e) begin
          errors++;
          $display("FAIL filter_level%0d k+%0d: din={%b,%b} want %b", lvl, j, din[3], nf_din, e);
        end
      end
    end
  endtask

  task automatic test_reserved();
    logic [CH-1:0] e;
    mode = '1;
    for (int unsigned j = 0; j < 20; j++) begin
      dout = CH'($urandom);
      dout_q.push_back(dout);
      tick();
      e = dout_q.pop_front();
      checks++;
      if (pin_dout !== e || pin_oe !== '0 || busy !== '0 || buf_dir !== '0) begin
        errors++;
        $display("FAIL reserved cyc%0d: pin_dout=%b want %b oe=%b busy=%b dir=%b want 0",
                 j, pin_dout, e, pin_oe, busy, buf_dir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_to_out();
    test_out_to_in();
    test_pp_to_od();
    test_toggle_in_turn();
    test_filter();
    test_reserved();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
